// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port 256x8 RAM between the CPU core
// (default owner) and the host loader/debug port, stalling the CPU while
// the host owns the RAM.
// Ports:
//   clk, rst (sync, active-low)
//   cpu_addr/cpu_wdata/cpu_rden/cpu_wren -> CPU request; cpu_rdata, cpu_stall back
//   host_req/host_we/host_addr/host_wdata -> host request
//   host_gnt, host_ack, host_rdata -> host status and read data
//   ram_addr/ram_data/ram_rden/ram_wren -> RAM port; ram_q <- RAM data (1-cycle)
module mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int BURST_MAX    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_rden,
  input  logic       cpu_wren,
  output logic [7:0] cpu_rdata,
  output logic       cpu_stall,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_gnt,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_rden,
  output logic       ram_wren,
  input  logic [7:0] ram_q
);

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    HOST_OWN = 2'd1,
    HOLDOFF  = 2'd2
  } state_t;

  localparam logic [7:0] LP_STARVE    = 8'(STARVE_LIMIT);
  localparam logic [7:0] LP_STARVE_M1 = 8'(STARVE_LIMIT - 1);
  localparam logic [7:0] LP_BURST_M1  = 8'(BURST_MAX - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_starve;
  logic [7:0] r_burst;
  logic       r_ack;
  logic       r_ack_rd;
  logic [7:0] r_rdata;

  logic       w_cpu_act;
  logic       w_host_acc;
  logic       w_enter_host;
  logic       w_rden;
  logic       w_wren;

  assign w_cpu_act    = cpu_rden | cpu_wren;
  assign w_host_acc   = (r_state == HOST_OWN) & host_req;
  assign w_enter_host = (w_next == HOST_OWN) & (r_state != HOST_OWN);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CPU_OWN: begin
        if (host_req && (!w_cpu_act || r_starve == LP_STARVE_M1))
          w_next = HOST_OWN;
      end
      HOST_OWN: begin
        if (!host_req || r_burst == LP_BURST_M1)
          w_next = HOLDOFF;
      end
      HOLDOFF: w_next = CPU_OWN;
      default: w_next = CPU_OWN;
    endcase
  end

  // Write wins when the CPU raises both strobes.
  always_comb begin
    ram_addr = cpu_addr;
    ram_data = cpu_wdata;
    w_rden   = cpu_rden & ~cpu_wren;
    w_wren   = cpu_wren;
    if (r_state == HOST_OWN) begin
      ram_addr = host_addr;
      ram_data = host_wdata;
      w_rden   = host_req & ~host_we;
      w_wren   = host_req & host_we;
    end
  end

  // No RAM access of any kind while reset is held.
  assign ram_rden  = rst & w_rden;
  assign ram_wren  = rst & w_wren;

  assign host_gnt  = (r_state == HOST_OWN);
  assign cpu_stall = (r_state == HOST_OWN);
  assign cpu_rdata = ram_q;
  assign host_ack  = r_ack;

  // RAM data arrives in the ack cycle, so pass it through then and
  // hold the captured copy afterwards.
  assign host_rdata = r_ack_rd ? ram_q : r_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= CPU_OWN;
      r_starve <= 8'd0;
      r_burst  <= 8'd0;
      r_ack    <= 1'b0;
      r_ack_rd <= 1'b0;
      r_rdata  <= 8'd0;
    end else begin
      r_state  <= w_next;
      r_ack    <= w_host_acc;
      r_ack_rd <= w_host_acc & ~host_we;
      if (r_ack_rd)
        r_rdata <= ram_q;
      if (w_enter_host)
        r_starve <= 8'd0;
      else if (r_state == CPU_OWN && host_req && w_cpu_act
               && r_starve != LP_STARVE)
        r_starve <= r_starve + 8'd1;
      if (w_enter_host)
        r_burst <= 8'd0;
      else if (w_host_acc)
        r_burst <= r_burst + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a host-ack scoreboard for
// mem_arbiter, driving a behavioural 256x8 synchronous RAM.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_rden;
  logic       cpu_wren;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_rden;
  logic       ram_wren;
  logic [7:0] ram_q = 8'd0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(8), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rden(cpu_rden), .cpu_wren(cpu_wren),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_ack(host_ack),
    .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_rden(ram_rden), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  logic [7:0] mem    [256];
  logic [7:0] shadow [256];

  always @(posedge clk) begin
    if (ram_wren === 1'b1) mem[ram_addr] <= ram_data;
    if (ram_rden === 1'b1) ram_q <= mem[ram_addr];
  end

  typedef struct {
    logic       rd;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (host_ack === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack, expected none");
      end else begin
        e = q.pop_front();
        if (e.rd) chk("host_rdata", host_rdata, e.d);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_access(input logic we, input logic [7:0] a,
                             input logic [7:0] d, output int waits);
    bit   done;
    exp_t e;
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    waits      = 0;
    done       = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (host_gnt === 1'b1) begin
        e.rd = ~we;
        e.d  = shadow[a];
        q.push_back(e);
        if (we) shadow[a] = d;
        done = 1'b1;
      end else if (waits >= 20) begin
        n_chk++;
        n_fail++;
        $display("FAIL grant_timeout: got no grant, expected one");
        done = 1'b1;
      end else begin
        waits++;
      end
      tick();
    end
  endtask

  task automatic cpu_read(input string nm, input logic [7:0] a);
    cpu_rden = 1'b1;
    cpu_wren = 1'b0;
    cpu_addr = a;
    tick();
    cpu_rden = 1'b0;
    @(negedge clk);
    chk(nm, cpu_rdata, shadow[a]);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int wexp [10];
    wexp = '{1, 0, 0, 0, 2, 0, 0, 0, 2, 0};
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'(i) ^ 8'hA5;
      shadow[i] = 8'(i) ^ 8'hA5;
    end

    // Reset held with both sides requesting
    rst        = 1'b0;
    cpu_addr   = 8'h10;
    cpu_wdata  = 8'hEE;
    cpu_rden   = 1'b0;
    cpu_wren   = 1'b1;
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 8'h10;
    host_wdata = 8'hBB;
    @(negedge clk);
    chk("rst_ram_wren0", ram_wren, 0);
    tick();
    @(negedge clk);
    chk("rst_ram_wren1", ram_wren, 0);
    chk("rst_gnt", host_gnt, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_ack", host_ack, 0);
    chk("rst_rdata", host_rdata, 0);
    tick();
    rst       = 1'b1;
    host_req  = 1'b0;
    cpu_wdata = 8'h5A;
    shadow[8'h10] = 8'h5A;
    @(negedge clk);
    chk("cpu_wr_strobe", ram_wren, 1);
    tick();
    cpu_wren = 1'b0;
    cpu_read("cpu_rd_10", 8'h10);

    // Idle grant: write then read back
    tick();
    host_access(1'b1, 8'h20, 8'hC3, w);
    chk("idle_gnt_lat", 8'(w), 1);
    host_access(1'b0, 8'h20, 8'h00, w);
    chk("idle_b2b", 8'(w), 0);
    host_req = 1'b0;
    @(negedge clk);
    chk("drop_gnt", host_gnt, 1);
    chk("drop_strobes", {ram_rden, ram_wren}, 0);
    tick();
    cpu_rden = 1'b1;
    cpu_addr = 8'h20;
    @(negedge clk);
    chk("holdoff_gnt", host_gnt, 0);
    chk("holdoff_stall", cpu_stall, 0);
    chk("holdoff_rden", ram_rden, 1);
    tick();
    cpu_rden = 1'b0;
    @(negedge clk);
    chk("holdoff_rdata", cpu_rdata, 8'hC3);
    chk("cpu_own_gnt", host_gnt, 0);
    tick();

    // Starvation: CPU reads every cycle
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h60;
    for (int i = 0; i < 8; i++) begin
      cpu_rden = 1'b1;
      cpu_addr = 8'h40 + 8'(i);
      @(negedge clk);
      chk("starve_gnt_early", host_gnt, 0);
      if (i > 0) chk("starve_cpu_rd", cpu_rdata, shadow[8'h40 + 8'(i - 1)]);
      tick();
    end
    cpu_rden = 1'b0;
    @(negedge clk);
    chk("starve_gnt", host_gnt, 1);
    chk("starve_stall", cpu_stall, 1);
    chk("starve_cpu_rd8", cpu_rdata, shadow[8'h47]);
    q.push_back('{rd: 1'b1, d: shadow[8'h60]});
    tick();
    host_req = 1'b0;
    tick();
    tick();
    tick();

    // Burst cap: 10 held reads
    for (int i = 0; i < 10; i++) begin
      host_access(1'b0, 8'(i), 8'h00, w);
      chk($sformatf("burst_wait%0d", i), 8'(w), 8'(wexp[i]));
    end
    host_req = 1'b0;
    tick();
    tick();
    tick();

    // Reset on the second host access
    host_access(1'b1, 8'h70, 8'h11, w);
    chk("mid_gnt_lat", 8'(w), 1);
    host_addr  = 8'h71;
    host_wdata = 8'h22;
    rst        = 1'b0;
    @(negedge clk);
    tick();
    rst      = 1'b1;
    host_req = 1'b0;
    @(negedge clk);
    chk("mid_gnt", host_gnt, 0);
    chk("mid_stall", cpu_stall, 0);
    chk("mid_ack", host_ack, 0);
    tick();
    cpu_read("mid_rd_71", 8'h71);
    cpu_read("mid_rd_70", 8'h70);

    // Dual strobe: write wins
    cpu_rden  = 1'b1;
    cpu_wren  = 1'b1;
    cpu_addr  = 8'h30;
    cpu_wdata = 8'h77;
    @(negedge clk);
    chk("dual_wren", ram_wren, 1);
    chk("dual_rden", ram_rden, 0);
    shadow[8'h30] = 8'h77;
    tick();
    cpu_rden = 1'b0;
    cpu_wren = 1'b0;
    cpu_read("dual_rd_30", 8'h30);

    tick();
    tick();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL acks_pending: got %0d left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-port 256×8 program/data RAM between the CPU core and an external host port (program loader / debug monitor). The CPU is the default owner. The host is granted the bus when the CPU leaves the RAM idle, or after a bounded starvation wait. While the host owns the RAM, the CPU is stalled. The block sits between the CPU's addr/data_in/rden/wren bus and the `ram` instance, and drives the stall input of `stage`.

## Interface
- STARVE_LIMIT, 8: host is force-granted after this many CPU-busy cycles with host_req pending (1..255).
- BURST_MAX, 4: maximum host accesses per grant (1..255).

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low; rst=0 at a rising edge resets the block.
- cpu_addr  in  8  CPU RAM address.
- cpu_wdata  in  8  CPU write data.
- cpu_rden  in  1  CPU read strobe.
- cpu_wren  in  1  CPU write strobe.
- cpu_rdata  out  8  RAM read data to the CPU; equals ram_q.
- cpu_stall  out  1  1 = stage must hold its state; CPU strobes are ignored.
- host_req  in  1  host requests access; addr, data and we are held stable until the access is performed.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  8  host address.
- host_wdata  in  8  host write data.
- host_gnt  out  1  host owns the RAM this cycle.
- host_ack  out  1  registered; the previous cycle's host access completed.
- host_rdata  out  8  registered read data; valid when host_ack=1 after a read.
- ram_addr  out  8  to RAM address.
- ram_data  out  8  to RAM write data.
- ram_rden  out  1  to RAM read enable.
- ram_wren  out  1  to RAM write enable.
- ram_q  in  8  RAM read data, 1-cycle latency.

## Operation
- States: CPU_OWN, HOST_OWN, HOLDOFF. Reset state is CPU_OWN.
- **CPU_OWN**
  - RAM port muxes the CPU signals combinationally. cpu_stall=0, host_gnt=0.
  - cpu_active = cpu_rden | cpu_wren. If both strobes are 1, ram_wren=1 and ram_rden=0.
  - starve_cnt increments, saturating at STARVE_LIMIT, each cycle with host_req & cpu_active.
  - Transition to HOST_OWN when host_req & (!cpu_active | starve_cnt==STARVE_LIMIT-1). The CPU access in that cycle still completes; it is never aborted.
- **HOST_OWN**
  - RAM port muxes the host signals. host_gnt=1, cpu_stall=1.
  - An access occurs when host_req=1: ram_rden=!host_we, ram_wren=host_we. With host_req=0, both strobes are 0.
  - burst_cnt increments per access.
  - Transition to HOLDOFF at the edge where host_req=0 or burst_cnt reaches BURST_MAX (i.e. after the BURST_MAX-th access).
- **HOLDOFF**
  - One cycle. Behaves as CPU_OWN, but host_req is ignored and not counted.
  - Always transitions to CPU_OWN. Guarantees the CPU at least one cycle between grants.
- starve_cnt and burst_cnt clear on entry to HOST_OWN and on reset.
- host_ack is registered: it is 1 in the cycle after each host access. host_rdata captures ram_q on that cycle (read case) and holds otherwise.
- cpu_rdata = ram_q at all times. A CPU read issued in the last CPU_OWN cycle returns data in the first HOST_OWN cycle; the CPU captures it normally.

## Timing
- Reset (rst=0 at an edge):
  - state=CPU_OWN; counters=0; host_ack=0; host_rdata=0.
  - host_gnt=0, cpu_stall=0.
  - While rst=0, ram_rden=ram_wren=0 regardless of inputs.
- Reset mid-burst: next cycle is CPU_OWN, any pending ack is dropped, and no further host access occurs.
- Grant latency:
  - CPU idle: host_req rising in cycle N gives host_gnt=1 in cycle N+1.
  - CPU busy every cycle: host_gnt=1 no later than STARVE_LIMIT cycles after host_req rises.
- A host access in cycle K gives host_ack=1 in cycle K+1. Back-to-back accesses give 1 ack per cycle.
- cpu_stall is combinational from state. It asserts in the same cycle as host_gnt and deasserts in the HOLDOFF cycle.
- host_req dropping in HOST_OWN: no access that cycle; HOLDOFF follows.

## Test plan
- **Reset:** drive rst=0 for 2 cycles with cpu_wren=1 and host_req=1 -> ram_wren=0, host_gnt=0, cpu_stall=0, host_ack=0. After release, CPU write addr 0x10 data 0x5A reaches the RAM.
- **Idle grant:** CPU strobes 0, host write addr 0x20=0xC3 then read 0x20 -> gnt in cycle N+1, writes performed, ack on each following cycle, host_rdata=0xC3. Then HOLDOFF, then CPU_OWN.
- **Starvation:** CPU reads every cycle, host_req held with STARVE_LIMIT=8 -> host_gnt rises exactly 8 cycles after host_req. The CPU's 8th read completes with correct cpu_rdata.
- **Burst cap:** BURST_MAX=4, host holds req for 10 reads at 0x00–0x09 -> 4 accesses, 1 HOLDOFF cycle with cpu_stall=0, then a regrant. All 10 acks are in order with correct data.
- **Reset mid-burst:** rst=0 on the 2nd host access -> next cycle CPU_OWN, host_gnt=0, host_ack=0. The RAM is unchanged beyond the accesses already completed.
- **Dual strobe:** CPU asserts cpu_rden=cpu_wren=1 at addr 0x30, data 0x77 -> ram_wren=1, ram_rden=0, and a later read returns 0x77.
